dmem_access_ctrl: RTL

- Sequencing controller and two-requester arbiter in front of the single-port 64-bit data memory.
- Requester 0 is the core load/store unit; requester 1 is the debug/loader port.
- Translates sized byte/half/word/dword loads and stores into memory-side MemRead/MemWrite cycles; sub-dword stores use read-modify-write.
- Returns sign- or zero-extended load data and flags misaligned accesses.

---
 rtl/dmem_access_ctrl_if.sv | 47 ++++
 rtl/dmem_access_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl_if
// Bundles the two-requester request bus, the response channel and the
// single-port data memory bus of dmem_access_ctrl.
//   req_*  : per-requester request (bit/slice 0 = core LSU, 1 = debug port)
//   rsp_*  : single response channel back to the granted requester
//   mem_*  : memory side (mem_rd is combinational from the memory)
// Modports:
//   slave  : the controller
//   master : requesters + memory model (the environment)
// ---------------------------------------------------------------------------
interface dmem_access_ctrl_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 64
);
  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [1:0]              req_we;
  logic [3:0]              req_size;
  logic [1:0]              req_unsigned;
  logic [2*DM_ADDRESS-1:0] req_addr;
  logic [2*DATA_W-1:0]     req_wdata;
  logic                    rsp_valid;
  logic                    rsp_id;
  logic                    rsp_ready;
  logic [DATA_W-1:0]       rsp_rdata;
  logic                    rsp_err;
  logic                    mem_read;
  logic                    mem_write;
  logic [DM_ADDRESS-1:0]   mem_addr;
  logic [DATA_W-1:0]       mem_wd;
  logic [DATA_W-1:0]       mem_rd;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  rsp_ready, mem_rd,
    output req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err,
    output mem_read, mem_write, mem_addr, mem_wd
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output rsp_ready, mem_rd,
    input  req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err,
    input  mem_read, mem_write, mem_addr, mem_wd
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl
// Round-robin arbiter + sequencer in front of a single-port 64-bit data
// memory. Sized loads read one dword and extend the selected lanes; sub-dword
// stores do read-modify-write; dword stores write directly; misaligned
// accesses respond with an error and never touch memory.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : dmem_access_ctrl_if.slave (request, response, memory buses)
//   busy   : high whenever the FSM is not IDLE (debug view of state)
//
// Handshakes: a transfer happens at the rising edge where valid and ready
// are both high. Requesters may drop valid before ready (no grant then);
// response outputs stay stable while rsp_valid is high and rsp_ready is low.
// ---------------------------------------------------------------------------
module dmem_access_ctrl #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  dmem_access_ctrl_if.slave  bus,
  output logic               busy
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  state_t                r_state, w_next;
  logic                  r_rr_last;
  logic [2:0]            r_off;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_uns;
  logic [DATA_W-1:0]     r_wdata;
  logic                  r_id;
  logic                  r_err;
  logic [DATA_W-1:0]     r_rdata;
  logic [DM_ADDRESS-1:0] r_mem_addr;
  logic [DATA_W-1:0]     r_mem_wd;
  logic                  r_mem_read;
  logic                  r_mem_write;

  logic                  w_any;
  logic                  w_gnt;
  logic [1:0]            w_req_ready;
  logic [DM_ADDRESS-1:0] w_sel_addr;
  logic [1:0]            w_sel_size;
  logic                  w_sel_we;
  logic                  w_sel_uns;
  logic [DATA_W-1:0]     w_sel_wdata;
  logic                  w_misal;

  // Replace lanes [off .. off+2^size-1] of base with the low bytes of wd.
  function automatic logic [DATA_W-1:0] f_merge(input logic [DATA_W-1:0] base,
                                                input logic [DATA_W-1:0] wd,
                                                input logic [2:0] off,
                                                input logic [1:0] size);
    logic [DATA_W-1:0] m;
    int o;
    int n;
    m = base;
    o = int'(off);
    n = 1 << size;
    for (int i = 0; i < 8; i++) begin
      if (i >= o && i < o + n) m[8*i +: 8] = wd[8*(i-o) +: 8];
    end
    return m;
  endfunction

  // Shift selected lanes down, then sign- or zero-extend to 64 bits.
  function automatic logic [DATA_W-1:0] f_load(input logic [DATA_W-1:0] d,
                                               input logic [2:0] off,
                                               input logic [1:0] size,
                                               input logic uns);
    logic [DATA_W-1:0] s;
    logic [DATA_W-1:0] r;
    s = d >> {off, 3'b000};
    unique case (size)
      2'd0:    r = {{56{s[7]  & ~uns}}, s[7:0]};
      2'd1:    r = {{48{s[15] & ~uns}}, s[15:0]};
      2'd2:    r = {{32{s[31] & ~uns}}, s[31:0]};
      default: r = s;
    endcase
    return r;
  endfunction

  // Arbitration: a lone requester wins; on a tie the one not served last wins.
  assign w_any       = |bus.req_valid;
  assign w_gnt       = (&bus.req_valid) ? ~r_rr_last : bus.req_valid[1];
  assign w_sel_addr  = w_gnt ? bus.req_addr[2*DM_ADDRESS-1:DM_ADDRESS]
                             : bus.req_addr[DM_ADDRESS-1:0];
  assign w_sel_size  = w_gnt ? bus.req_size[3:2] : bus.req_size[1:0];
  assign w_sel_we    = bus.req_we[w_gnt];
  assign w_sel_uns   = bus.req_unsigned[w_gnt];
  assign w_sel_wdata = w_gnt ? bus.req_wdata[2*DATA_W-1:DATA_W]
                             : bus.req_wdata[DATA_W-1:0];
  assign w_misal     = ((w_sel_size == 2'd1) &&  w_sel_addr[0])      ||
                       ((w_sel_size == 2'd2) && |w_sel_addr[1:0])    ||
                       ((w_sel_size == 2'd3) && |w_sel_addr[2:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_req_ready = 2'b00;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_req_ready[w_gnt] = 1'b1;
          if (w_misal)                                w_next = S_RESP;
          else if (!w_sel_we || w_sel_size != 2'd3)   w_next = S_RD;
          else                                        w_next = S_WR;
        end
      end
      S_RD:    w_next = r_we ? S_WR : S_RESP;
      S_WR:    w_next = S_RESP;
      S_RESP:  if (bus.rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // mem_read/mem_write come straight from flops so they cannot glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_last   <= 1'b1;
      r_off       <= '0;
      r_we        <= 1'b0;
      r_size      <= '0;
      r_uns       <= 1'b0;
      r_wdata     <= '0;
      r_id        <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wd    <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else begin
      r_mem_read  <= (w_next == S_RD);
      r_mem_write <= (w_next == S_WR);
      if (r_state == S_IDLE && w_any) begin
        r_off     <= w_sel_addr[2:0];
        r_we      <= w_sel_we;
        r_size    <= w_sel_size;
        r_uns     <= w_sel_uns;
        r_wdata   <= w_sel_wdata;
        r_id      <= w_gnt;
        r_rr_last <= w_gnt;
        r_err     <= w_misal;
        r_rdata   <= '0;
        if (!w_misal) r_mem_addr <= {w_sel_addr[DM_ADDRESS-1:3], 3'b000};
        if (!w_misal && w_sel_we && w_sel_size == 2'd3) r_mem_wd <= w_sel_wdata;
      end else if (r_state == S_RD) begin
        if (r_we) r_mem_wd <= f_merge(bus.mem_rd, r_wdata, r_off, r_size);
        else      r_rdata  <= f_load(bus.mem_rd, r_off, r_size, r_uns);
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_id    = (r_state == S_RESP) & r_id;
  assign bus.rsp_err   = (r_state == S_RESP) & r_err;
  assign bus.rsp_rdata = (r_state == S_RESP) ? r_rdata : '0;
  assign bus.mem_read  = r_mem_read;
  assign bus.mem_write = r_mem_write;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wd    = r_mem_wd;
  assign busy          = (r_state != S_IDLE);

endmodule
